// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-subset control unit.
// A Moore FSM sequences fetch/decode/execute/writeback over a unified memory
// with a mem_ready handshake. pc_en and ir_write are the only outputs that also
// depend on inputs. The retired-instruction counter advances on every completed
// instruction, and an unknown opcode parks the FSM in ILLEGAL until reset.
module multi_cycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  typedef enum logic [3:0] {
    RST, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, ILLEGAL
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] retired_reg;
  logic             retire;

  // State register; reset takes effect immediately, even mid-stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= RST;
    else       state_reg <= state_next;
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retired_reg <= '0;
    else if (retire) retired_reg <= retired_reg + CNT_W'(1);
  end

  assign instr_retired = retired_reg;

  // Next-state and output decode; everything defaults to idle.
  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    illegal    = 1'b0;
    case (state_reg)
      RST: state_next = FETCH;
      FETCH: begin
        // PC+4 is computed every fetch cycle but only committed with the IR.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        // Branch target computed speculatively while the opcode is decoded.
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:                          state_next = R_EXEC;
          OP_LW, OP_SW:                      state_next = MEM_ADDR;
          OP_BEQ, OP_BNE:                    state_next = BRANCH;
          OP_J:                              state_next = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = I_EXEC;
          default:                           state_next = ILLEGAL;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // IR is stable here, so lw/sw can be told apart without latching.
        if (opcode == OP_LW)      state_next = MEM_RD;
        else if (opcode == OP_SW) state_next = MEM_WR;
        else                      state_next = ILLEGAL;
      end
      MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_next = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = FETCH;
        retire     = 1'b1;
      end
      MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          state_next = FETCH;
          retire     = 1'b1;
        end
      end
      R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        state_next = R_WB;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        state_next = FETCH;
        retire     = 1'b1;
      end
      I_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_op     = 2'b11;
        state_next = I_WB;
      end
      I_WB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
        retire     = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_source  = 2'b01;
        pc_en      = (opcode == OP_BNE) ? ~zero : zero;
        state_next = FETCH;
        retire     = 1'b1;
      end
      JUMP: begin
        pc_source  = 2'b10;
        pc_en      = 1'b1;
        state_next = FETCH;
        retire     = 1'b1;
      end
      ILLEGAL: illegal = 1'b1;
      default: state_next = RST;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-cycle output vectors are compared
// against hand-built constants for each state, plus counter checks.
module tb_multi_cycle_control;

  localparam int CNT_W = 4;

  // Output vector layout:
  // {pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
  //  mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0], illegal}
  localparam logic [15:0] V_RST      = 16'h0000;
  localparam logic [15:0] V_FETCH    = 16'hA820;
  localparam logic [15:0] V_FSTALL   = 16'h2020;
  localparam logic [15:0] V_DECODE   = 16'h0060;
  localparam logic [15:0] V_MEMADDR  = 16'h00C0;
  localparam logic [15:0] V_MEMRD    = 16'h6000;
  localparam logic [15:0] V_MEMWB    = 16'h0500;
  localparam logic [15:0] V_MEMWR    = 16'h5000;
  localparam logic [15:0] V_REXEC    = 16'h0090;
  localparam logic [15:0] V_RWB      = 16'h0600;
  localparam logic [15:0] V_IEXEC    = 16'h00D8;
  localparam logic [15:0] V_IWB      = 16'h0400;
  localparam logic [15:0] V_BR_TAKEN = 16'h808A;
  localparam logic [15:0] V_BR_NOT   = 16'h008A;
  localparam logic [15:0] V_JUMP     = 16'h8004;
  localparam logic [15:0] V_ILLEGAL  = 16'h0001;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [5:0]       opcode = 6'b0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b1;
  logic             pc_en, iord, mem_read, mem_write, ir_write;
  logic             reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [CNT_W-1:0] instr_retired;
  logic [15:0]      outv;

  int err_cnt = 0;
  int chk_cnt = 0;

  multi_cycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .illegal(illegal),
    .instr_retired(instr_retired)
  );

  assign outv = {pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
                 mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Let freshly driven inputs settle, then compare the output vector.
  task automatic expect_out(input string tag, input logic [15:0] exp);
    #1;
    check(tag, {16'h0, outv}, {16'h0, exp});
  endtask

  task automatic expect_cnt(input string tag, input int exp);
    check(tag, {{(32-CNT_W){1'b0}}, instr_retired}, exp & ((1 << CNT_W) - 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_cnt;

  initial begin
    // Power-on reset
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset_outs", V_RST);
    expect_cnt("reset_cnt", 0);
    reset = 1'b0;
    expect_out("rst_state", V_RST);
    tick();

    // R-type, no stalls
    opcode = 6'b000000; mem_ready = 1'b1;
    expect_out("r_fetch", V_FETCH);   tick();
    expect_out("r_decode", V_DECODE); tick();
    expect_out("r_exec", V_REXEC);    tick();
    expect_out("r_wb", V_RWB);        expect_cnt("r_cnt_before", 0); tick();
    expect_cnt("r_cnt", 1);

    // lw: FETCH stall with garbage opcode, two MEM_RD stalls with garbage opcode
    mem_ready = 1'b0; opcode = 6'b111111;
    expect_out("lw_fstall", V_FSTALL); tick();
    mem_ready = 1'b1; opcode = 6'b100011;
    expect_out("lw_fetch", V_FETCH);    tick();
    expect_out("lw_decode", V_DECODE);  tick();
    expect_out("lw_addr", V_MEMADDR);   tick();
    mem_ready = 1'b0; opcode = 6'b111111;
    expect_out("lw_rd_stall1", V_MEMRD); tick();
    expect_out("lw_rd_stall2", V_MEMRD); tick();
    mem_ready = 1'b1;
    expect_out("lw_rd_done", V_MEMRD);  tick();
    expect_out("lw_wb", V_MEMWB);       tick();
    expect_cnt("lw_cnt", 2);

    // sw, no stalls
    opcode = 6'b101011;
    expect_out("sw_fetch", V_FETCH);   tick();
    expect_out("sw_decode", V_DECODE); tick();
    expect_out("sw_addr", V_MEMADDR);  tick();
    expect_out("sw_wr", V_MEMWR);      tick();
    expect_cnt("sw_cnt", 3);

    // I-type (ori)
    opcode = 6'b001101;
    expect_out("i_fetch", V_FETCH);   tick();
    expect_out("i_decode", V_DECODE); tick();
    expect_out("i_exec", V_IEXEC);    tick();
    expect_out("i_wb", V_IWB);        tick();
    expect_cnt("i_cnt", 4);

    // Branches: beq/bne with zero=1 and zero=0
    for (int b = 0; b < 4; b++) begin
      opcode = (b < 2) ? 6'b000100 : 6'b000101;
      expect_out("br_fetch", V_FETCH);   tick();
      expect_out("br_decode", V_DECODE); tick();
      zero = (b % 2 == 0);
      expect_out((b < 2) ? "beq_branch" : "bne_branch",
                 ((b < 2) == zero) ? V_BR_TAKEN : V_BR_NOT);
      tick();
      expect_cnt("br_cnt", 5 + b);
    end

    // 16 jumps on a 4-bit counter: 8 .. 15 -> 0 .. 8
    opcode = 6'b000010;
    exp_cnt = 8;
    for (int j = 0; j < 16; j++) begin
      tick(); tick();
      expect_out("jump", V_JUMP);
      tick();
      exp_cnt++;
      expect_cnt("jump_cnt", exp_cnt);
    end

    // Illegal opcode: terminal, no strobes, counter frozen
    opcode = 6'b111111;
    expect_out("ill_fetch", V_FETCH);   tick();
    expect_out("ill_decode", V_DECODE); tick();
    opcode = 6'b000000;
    for (int k = 0; k < 20; k++) begin
      mem_ready = k[0];
      expect_out("ill_hold", V_ILLEGAL);
      tick();
    end
    expect_cnt("ill_cnt", 8);
    reset = 1'b1;
    expect_out("ill_reset", V_RST);
    expect_cnt("ill_reset_cnt", 0);
    tick();
    reset = 1'b0; mem_ready = 1'b1;
    tick();

    // sw with MEM_WR stall, reset asserted mid-stall
    opcode = 6'b101011;
    expect_out("swr_fetch", V_FETCH);   tick();
    expect_out("swr_decode", V_DECODE); tick();
    expect_out("swr_addr", V_MEMADDR);  tick();
    mem_ready = 1'b0;
    expect_out("swr_stall1", V_MEMWR);  tick();
    expect_out("swr_stall2", V_MEMWR);
    reset = 1'b1;
    expect_out("swr_async_rst", V_RST);
    expect_cnt("swr_rst_cnt", 0);
    tick();
    reset = 1'b0; mem_ready = 1'b1;
    expect_out("swr_rst_state", V_RST); tick();
    expect_out("swr_restart", V_FETCH);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
